// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad code-entry front end.
package keypad_pkg;

    localparam int DIGIT_W  = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EVAL
    } state_e;

    // Index of the (single) set bit; callers guarantee one-hot input.
    function automatic logic [DIGIT_W-1:0] onehot_to_digit(input logic [NUM_KEYS-1:0] onehot);
        logic [DIGIT_W-1:0] digit;
        digit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (onehot[i]) digit = DIGIT_W'(i);
        end
        return digit;
    endfunction

    function automatic logic popcount_gt1(input logic [NUM_KEYS-1:0] vec);
        return (vec & (vec - NUM_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detection for the digit keys and the cancel button.
module key_edge_detect #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key,
    input  logic             clear_key,
    output logic [WIDTH-1:0] press,
    output logic             clear_edge
);

    logic [WIDTH-1:0] key_q, key_d;
    logic             clr_q, clr_d;

    always_comb begin
        key_d = key;
        clr_d = clear_key;
    end

    // NOTE: history resets to all-ones so a key held through reset is not a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_q <= '1;
            clr_q <= 1'b1;
        end else begin
            key_q <= key_d;
            clr_q <= clr_d;
        end
    end

    assign press      = key & ~key_q;
    assign clear_edge = clear_key & ~clr_q;

endmodule

// File: rtl/keypad_code_entry.sv
// Collects CODE_LEN keypad digits into one attempt and reports pass/fail,
// with cancel, inactivity timeout, multi-key rejection and lockout gating.
module keypad_code_entry
    import keypad_pkg::*;
#(
    parameter int                            CODE_LEN    = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   SECRET      = 16'h1234,
    parameter int                            TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_KEYS-1:0]           key,
    input  logic                          clear_key,
    input  logic                          locked,
    output logic                          attempt_valid,
    output logic                          attempt_ok,
    output logic                          key_err,
    output logic                          timeout,
    output logic [$clog2(CODE_LEN+1)-1:0] digit_count
);

    localparam int BUF_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W = $clog2(CODE_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               key_err_q, key_err_d;
    logic               timeout_q, timeout_d;

    logic [NUM_KEYS-1:0] press;
    logic                clear_edge;
    logic                multi_key;
    logic                accept;

    key_edge_detect #(
        .WIDTH (NUM_KEYS)
    ) u_edge (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .clear_key  (clear_key),
        .press      (press),
        .clear_edge (clear_edge)
    );

    assign multi_key = popcount_gt1(press);
    assign accept    = (press != '0) && !multi_key && !locked && !clear_edge
                       && (state_q != EVAL);

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        count_d   = count_q;
        timer_d   = timer_q;
        key_err_d = multi_key;
        timeout_d = 1'b0;

        if (state_q == EVAL) begin
            // The attempt always completes; presses and clears here are dropped.
            state_d = IDLE;
            buf_d   = '0;
            count_d = '0;
            timer_d = '0;
        end else if (clear_edge || locked) begin
            state_d = IDLE;
            buf_d   = '0;
            count_d = '0;
            timer_d = '0;
        end else if (accept) begin
            buf_d   = (buf_q << DIGIT_W) | BUF_W'(onehot_to_digit(press));
            count_d = count_q + CNT_W'(1);
            timer_d = '0;
            state_d = (count_q == CNT_LAST) ? EVAL : COLLECT;
        end else if (state_q == COLLECT) begin
            if (timer_q == TMR_LAST) begin
                state_d   = IDLE;
                buf_d     = '0;
                count_d   = '0;
                timer_d   = '0;
                timeout_d = 1'b1;
            end else if (timer_q != TMR_MAX) begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            key_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            key_err_q <= key_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign attempt_valid = (state_q == EVAL);
    assign attempt_ok    = attempt_valid && (buf_q == SECRET);
    assign key_err       = key_err_q;
    assign timeout       = timeout_q;
    assign digit_count   = count_q;

endmodule
